mmc3_gen: RTL and testbench

Parametrised MMC3-class bank and IRQ core, the next generation of the fixed MMC3 chip model. It adds configurable PRG/CHR bank widths, a selectable IRQ silicon revision, and a configurable PPU A12 rise filter. It sits inside a mapper top, between the CPU/PPU bus bundles and the PRG/CHR/SRAM address pins. All state is clocked on the single mapper clock, and CPU writes commit on a sampled M2 falling edge.

---
 rtl/mmc3_gen.sv | 157 +++++++++++++++
 tb/tb_mmc3_gen.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc3_gen.sv
// MMC3-class PRG/CHR bank mapper and scanline IRQ core with configurable bank widths,
// IRQ silicon revision and PPU A12 rise filter.
module mmc3_gen #(
    parameter int PRG_W    = 6,
    parameter int CHR_W    = 8,
    parameter int IRQ_REV  = 1,
    parameter int A12_FILT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      cpu_addr,
    input  logic [7:0]       cpu_data,
    input  logic             cpu_rw,
    input  logic             cpu_m2,
    input  logic [2:0]       ppu_addr,
    input  logic             mir_h,
    output logic [PRG_W-1:0] prg_addr,
    output logic [CHR_W-1:0] chr_addr,
    output logic             prg_ce,
    output logic             ram_ce,
    output logic             ram_we,
    output logic             ciram_a10,
    output logic             irq
);
    localparam logic [3:0]       FILT_TH = 4'(A12_FILT);
    localparam logic [PRG_W-1:0] LAST    = '1;
    localparam logic [PRG_W-1:0] LAST_M1 = {{(PRG_W-1){1'b1}}, 1'b0};

    logic [2:0]            m2_pipe;   // [0],[1] synchronizer, [2] edge register
    logic                  m2_fall, wr_stb, wr_c001, wr_e000;
    logic [2:0]            reg_sel, bank_idx;
    logic [CHR_W-1:0]      chr_data, lo_bank;
    logic                  prg_mode, chr_inv, mirror, ram_en, ram_wp;
    logic [PRG_W-1:0]      prg_r6, prg_r7;
    logic [5:0][CHR_W-1:0] chr_r;
    logic [7:0]            irq_latch, irq_cnt, cnt_next;
    logic                  reload, irq_en, a12_d, a12_eff, scan_clk, rev_ok, irq_set;
    logic [3:0]            filt_cnt;
    logic                  unused_addr;

    generate
        if (CHR_W <= 8) begin : g_chr_narrow
            assign chr_data = cpu_data[CHR_W-1:0];
        end else begin : g_chr_wide
            assign chr_data = {{(CHR_W-8){1'b0}}, cpu_data};
        end
    endgenerate

    assign unused_addr = ^cpu_addr[12:1];
    assign m2_fall  = m2_pipe[2] & ~m2_pipe[1];
    assign wr_stb   = m2_fall & ~cpu_rw & cpu_addr[15];
    assign reg_sel  = {cpu_addr[14:13], cpu_addr[0]};
    assign wr_c001  = wr_stb & (reg_sel == 3'b101);
    assign wr_e000  = wr_stb & (reg_sel == 3'b110);
    assign scan_clk = ppu_addr[2] & ~a12_d & (filt_cnt >= FILT_TH);
    assign cnt_next = (irq_cnt == 8'd0 || reload) ? irq_latch : irq_cnt - 8'd1;
    // Rev A only fires on a natural reach of zero, never from a steady latch of 0.
    assign rev_ok   = (IRQ_REV != 0) || (irq_cnt != 8'd0) || reload || (irq_latch != 8'd0);
    assign irq_set  = scan_clk & ~wr_c001 & irq_en & (cnt_next == 8'd0) & rev_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m2_pipe   <= '0;
            a12_d     <= 1'b0;
            filt_cnt  <= FILT_TH;
            bank_idx  <= '0;
            prg_mode  <= 1'b0;
            chr_inv   <= 1'b0;
            mirror    <= mir_h;
            ram_en    <= 1'b1;
            ram_wp    <= 1'b0;
            prg_r6    <= '0;
            prg_r7    <= {{(PRG_W-1){1'b0}}, 1'b1};
            chr_r     <= '0;
            irq_latch <= '0;
            irq_cnt   <= '0;
            reload    <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            m2_pipe <= {m2_pipe[1:0], cpu_m2};
            a12_d   <= ppu_addr[2];
            if (ppu_addr[2])
                filt_cnt <= '0;
            else if (m2_fall && filt_cnt != 4'hF)
                filt_cnt <= filt_cnt + 4'd1;

            if (wr_stb) begin
                case (reg_sel)
                    3'b000: begin
                        bank_idx <= cpu_data[2:0];
                        prg_mode <= cpu_data[6];
                        chr_inv  <= cpu_data[7];
                    end
                    3'b001: begin
                        if (bank_idx == 3'd6) prg_r6 <= cpu_data[PRG_W-1:0];
                        if (bank_idx == 3'd7) prg_r7 <= cpu_data[PRG_W-1:0];
                        for (int i = 0; i < 6; i++)
                            if (bank_idx == 3'(i)) chr_r[i] <= chr_data;
                    end
                    3'b010: mirror <= cpu_data[0];
                    3'b011: begin
                        ram_en <= cpu_data[7];
                        ram_wp <= cpu_data[6];
                    end
                    3'b100: irq_latch <= cpu_data;
                    3'b110: irq_en <= 1'b0;
                    3'b111: irq_en <= 1'b1;
                    default: ;
                endcase
            end

            // A $C001 write in the same cycle as a scanline clock swallows the clock.
            if (wr_c001) begin
                irq_cnt <= '0;
                reload  <= 1'b1;
            end else if (scan_clk) begin
                irq_cnt <= cnt_next;
                reload  <= 1'b0;
            end

            if (wr_e000)
                irq <= 1'b0;
            else if (irq_set)
                irq <= 1'b1;
        end
    end

    always_comb begin
        prg_ce    = cpu_addr[15];
        ram_ce    = (cpu_addr[15:13] == 3'b011) & ram_en;
        ram_we    = ram_ce & ~ram_wp & ~cpu_rw;
        ciram_a10 = mirror ? ppu_addr[1] : ppu_addr[0];

        prg_addr = LAST;
        case (cpu_addr[14:13])
            2'd0:    prg_addr = prg_mode ? LAST_M1 : prg_r6;
            2'd1:    prg_addr = prg_r7;
            2'd2:    prg_addr = prg_mode ? prg_r6 : LAST_M1;
            default: prg_addr = LAST;
        endcase

        a12_eff  = ppu_addr[2] ^ chr_inv;
        lo_bank  = ppu_addr[1] ? chr_r[1] : chr_r[0];
        chr_addr = lo_bank;
        if (!a12_eff) begin
            chr_addr[0] = ppu_addr[0];
        end else begin
            case (ppu_addr[1:0])
                2'd0:    chr_addr = chr_r[2];
                2'd1:    chr_addr = chr_r[3];
                2'd2:    chr_addr = chr_r[4];
                default: chr_addr = chr_r[5];
            endcase
        end
    end
endmodule

// File: tb/tb_mmc3_gen.sv
// Scoreboard bench for mmc3_gen: rev B instance plus a rev A twin on the same buses.
module tb_mmc3_gen;
    localparam int PW = 6;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, cpu_rw, cpu_m2, mir_h;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_data;
    logic [2:0]    ppu_addr;
    logic [PW-1:0] prg_addr, prg_addr_a;
    logic [CW-1:0] chr_addr, chr_addr_a;
    logic          prg_ce, ram_ce, ram_we, ciram_a10, irq;
    logic          prg_ce_a, ram_ce_a, ram_we_a, ciram_a10_a, irq_a;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp;

    mmc3_gen #(.PRG_W(PW), .CHR_W(CW), .IRQ_REV(1), .A12_FILT(3)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .cpu_m2(cpu_m2), .ppu_addr(ppu_addr), .mir_h(mir_h),
        .prg_addr(prg_addr), .chr_addr(chr_addr), .prg_ce(prg_ce), .ram_ce(ram_ce),
        .ram_we(ram_we), .ciram_a10(ciram_a10), .irq(irq));

    mmc3_gen #(.PRG_W(PW), .CHR_W(CW), .IRQ_REV(0), .A12_FILT(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .cpu_m2(cpu_m2), .ppu_addr(ppu_addr), .mir_h(mir_h),
        .prg_addr(prg_addr_a), .chr_addr(chr_addr_a), .prg_ce(prg_ce_a), .ram_ce(ram_ce_a),
        .ram_we(ram_we_a), .ciram_a10(ciram_a10_a), .irq(irq_a));

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_data = d; cpu_rw = 1'b0; cpu_m2 = 1'b1;
        cyc(2); cpu_m2 = 1'b0;
        cyc(6); cpu_m2 = 1'b1;
        cyc(2); cpu_rw = 1'b1; cpu_addr = 16'h0000;
    endtask

    task automatic m2_pulse();
        @(negedge clk);
        cpu_rw = 1'b1; cpu_addr = 16'h0000; cpu_m2 = 1'b0;
        cyc(4); cpu_m2 = 1'b1;
        cyc(4);
    endtask

    task automatic a12_rise(input int falls);
        @(negedge clk); ppu_addr[2] = 1'b0;
        repeat (falls) m2_pulse();
        @(negedge clk); ppu_addr[2] = 1'b1;
        cyc(3); ppu_addr[2] = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(2);
    endtask

    task automatic test_reset();
        mir_h = 1'b1;
        do_reset();
        exp_q.push_back(16'd0); exp_q.push_back(16'd1);
        exp_q.push_back(16'd62); exp_q.push_back(16'd63);
        for (int w = 0; w < 4; w++) begin
            cpu_addr = 16'(16'h8000 + w * 16'h2000); #1;
            exp = exp_q.pop_front(); checks++;
            if (prg_addr !== exp[PW-1:0] || prg_addr_a !== exp[PW-1:0] || prg_ce !== 1'b1 || prg_ce_a !== 1'b1) begin
                errors++; $display("FAIL reset_prg_win%0d: got %0d/%0d ce=%b want %0d", w, prg_addr, prg_addr_a, prg_ce, exp);
            end
        end
        exp_q.push_back(16'h0000);
        cpu_addr = 16'h0000; ppu_addr = 3'b010; #1;
        exp = exp_q.pop_front(); checks++;
        if (irq !== exp[0] || irq_a !== exp[0] || chr_addr !== exp[7:0] || chr_addr_a !== exp[7:0]) begin
            errors++; $display("FAIL reset_irq_chr: irq=%b/%b chr=%h/%h want 0", irq, irq_a, chr_addr, chr_addr_a);
        end
        exp_q.push_back(16'd1); exp_q.push_back(16'd0);
        for (int p = 0; p < 2; p++) begin
            ppu_addr = (p == 0) ? 3'b010 : 3'b001; #1;
            exp = exp_q.pop_front(); checks++;
            if (ciram_a10 !== exp[0] || ciram_a10_a !== exp[0]) begin
                errors++; $display("FAIL reset_ciram%0d: got %b/%b want %b", p, ciram_a10, ciram_a10_a, exp[0]);
            end
        end
        exp_q.push_back(16'b11);
        cpu_addr = 16'h6000; cpu_rw = 1'b0; #1;
        exp = exp_q.pop_front(); checks++;
        if ({ram_ce, ram_we} !== exp[1:0] || {ram_ce_a, ram_we_a} !== exp[1:0] || prg_ce !== 1'b0) begin
            errors++; $display("FAIL reset_ram: ce/we=%b%b want %b prg_ce=%b", ram_ce, ram_we, exp[1:0], prg_ce);
        end
        cpu_rw = 1'b1; cpu_addr = 16'h0000; ppu_addr = 3'b000;
    endtask

    task automatic test_prg();
        exp_q.push_back(16'd62); exp_q.push_back(16'd1);
        exp_q.push_back(16'd5);  exp_q.push_back(16'd63);
        cpu_write(16'h8000, 8'h46);
        cpu_write(16'h8001, 8'h05);
        for (int w = 0; w < 4; w++) begin
            cpu_addr = 16'(16'h8000 + w * 16'h2000); #1;
            exp = exp_q.pop_front(); checks++;
            if (prg_addr !== exp[PW-1:0]) begin
                errors++; $display("FAIL prg_mode1_win%0d: got %0d want %0d", w, prg_addr, exp);
            end
        end
        cpu_addr = 16'h0000;
    endtask

    task automatic test_chr_latency();
        cpu_write(16'h8000, 8'h42);
        ppu_addr = 3'b100;
        exp_q.push_back(16'h00); exp_q.push_back(16'h05);
        @(negedge clk);
        cpu_addr = 16'h8001; cpu_data = 8'h05; cpu_rw = 1'b0; cpu_m2 = 1'b1;
        cyc(2); cpu_m2 = 1'b0;
        cyc(2); #1;
        exp = exp_q.pop_front(); checks++;
        if (chr_addr !== exp[7:0]) begin
            errors++; $display("FAIL latency_early: chr=%h want %h", chr_addr, exp[7:0]);
        end
        cyc(1); #1;
        exp = exp_q.pop_front(); checks++;
        if (chr_addr !== exp[7:0]) begin
            errors++; $display("FAIL latency_commit: chr=%h want %h", chr_addr, exp[7:0]);
        end
        cyc(2); cpu_m2 = 1'b1; cyc(2); cpu_rw = 1'b1; cpu_addr = 16'h0000; ppu_addr = 3'b000;
    endtask

    task automatic test_chr();
        cpu_write(16'h8000, 8'h82); cpu_write(16'h8001, 8'h33);
        cpu_write(16'h8000, 8'h80); cpu_write(16'h8001, 8'h0A);
        exp_q.push_back(16'h0B); exp_q.push_back(16'h33); exp_q.push_back(16'h01);
        for (int p = 0; p < 3; p++) begin
            ppu_addr = (p == 0) ? 3'b101 : (p == 1) ? 3'b000 : 3'b111; #1;
            exp = exp_q.pop_front(); checks++;
            if (chr_addr !== exp[7:0]) begin
                errors++; $display("FAIL chr_inv_%0d: ppu=%b chr=%h want %h", p, ppu_addr, chr_addr, exp[7:0]);
            end
        end
        ppu_addr = 3'b000;
    endtask

    task automatic test_mirror_ram();
        cpu_write(16'hA000, 8'h00);
        exp_q.push_back(16'd1); exp_q.push_back(16'd0);
        for (int p = 0; p < 2; p++) begin
            ppu_addr = (p == 0) ? 3'b001 : 3'b010; #1;
            exp = exp_q.pop_front(); checks++;
            if (ciram_a10 !== exp[0]) begin
                errors++; $display("FAIL mirror_v%0d: got %b want %b", p, ciram_a10, exp[0]);
            end
        end
        ppu_addr = 3'b000;
        cpu_write(16'hA001, 8'hC0);
        exp_q.push_back(16'b10);
        cpu_addr = 16'h7FFF; cpu_rw = 1'b0; #1;
        exp = exp_q.pop_front(); checks++;
        if ({ram_ce, ram_we} !== exp[1:0]) begin
            errors++; $display("FAIL ram_wp: ce/we=%b%b want %b", ram_ce, ram_we, exp[1:0]);
        end
        cpu_rw = 1'b1; cpu_addr = 16'h0000;
        cpu_write(16'hA001, 8'h00);
        exp_q.push_back(16'b00);
        cpu_addr = 16'h6000; cpu_rw = 1'b0; #1;
        exp = exp_q.pop_front(); checks++;
        if ({ram_ce, ram_we} !== exp[1:0]) begin
            errors++; $display("FAIL ram_disable: ce/we=%b%b want %b", ram_ce, ram_we, exp[1:0]);
        end
        cpu_rw = 1'b1; cpu_addr = 16'h0000;
    endtask

    task automatic test_irq();
        cpu_write(16'hC000, 8'h02); cpu_write(16'hC001, 8'h00); cpu_write(16'hE001, 8'h00);
        exp_q.push_back(16'b00); exp_q.push_back(16'b00);
        for (int k = 0; k < 2; k++) begin
            a12_rise(3);
            exp = exp_q.pop_front(); checks++;
            if ({irq, irq_a} !== exp[1:0]) begin
                errors++; $display("FAIL irq_rise%0d: irq b/a=%b%b want %b", k + 1, irq, irq_a, exp[1:0]);
            end
        end
        exp_q.push_back(16'b00); exp_q.push_back(16'b11);
        repeat (3) m2_pulse();
        @(negedge clk); ppu_addr[2] = 1'b1; #1;
        exp = exp_q.pop_front(); checks++;
        if ({irq, irq_a} !== exp[1:0]) begin
            errors++; $display("FAIL irq_rise3_early: irq b/a=%b%b want %b", irq, irq_a, exp[1:0]);
        end
        cyc(1);
        exp = exp_q.pop_front(); checks++;
        if ({irq, irq_a} !== exp[1:0]) begin
            errors++; $display("FAIL irq_rise3: irq b/a=%b%b want %b", irq, irq_a, exp[1:0]);
        end
        cyc(2); ppu_addr[2] = 1'b0;
        cpu_write(16'hE001, 8'h00);
        exp_q.push_back(16'b11);
        exp = exp_q.pop_front(); checks++;
        if ({irq, irq_a} !== exp[1:0]) begin
            errors++; $display("FAIL irq_hold_e001: irq b/a=%b%b want %b", irq, irq_a, exp[1:0]);
        end
        cpu_write(16'hE000, 8'h00);
        exp_q.push_back(16'b00);
        exp = exp_q.pop_front(); checks++;
        if ({irq, irq_a} !== exp[1:0]) begin
            errors++; $display("FAIL irq_ack: irq b/a=%b%b want %b", irq, irq_a, exp[1:0]);
        end
    endtask

    task automatic test_filter();
        cpu_write(16'hC000, 8'h01); cpu_write(16'hC001, 8'h00); cpu_write(16'hE001, 8'h00);
        exp_q.push_back(16'b00); exp_q.push_back(16'b00);
        exp_q.push_back(16'b00); exp_q.push_back(16'b11);
        for (int k = 0; k < 4; k++) begin
            a12_rise((k == 0) ? 3 : k);
            exp = exp_q.pop_front(); checks++;
            if ({irq, irq_a} !== exp[1:0]) begin
                errors++; $display("FAIL filter_step%0d: irq b/a=%b%b want %b", k, irq, irq_a, exp[1:0]);
            end
        end
        cpu_write(16'hE000, 8'h00);
    endtask

    task automatic test_simul();
        a12_rise(3);
        cpu_write(16'hE001, 8'h00);
        repeat (3) m2_pulse();
        exp_q.push_back(16'b00);
        @(negedge clk);
        cpu_addr = 16'hC001; cpu_data = 8'h00; cpu_rw = 1'b0; cpu_m2 = 1'b1;
        cyc(2); cpu_m2 = 1'b0;
        cyc(2); ppu_addr[2] = 1'b1;
        cyc(1);
        exp = exp_q.pop_front(); checks++;
        if ({irq, irq_a} !== exp[1:0]) begin
            errors++; $display("FAIL simul_c001: irq b/a=%b%b want %b", irq, irq_a, exp[1:0]);
        end
        cyc(2); cpu_m2 = 1'b1; ppu_addr[2] = 1'b0;
        cyc(2); cpu_rw = 1'b1; cpu_addr = 16'h0000;
        exp_q.push_back(16'b00); exp_q.push_back(16'b11);
        for (int k = 0; k < 2; k++) begin
            a12_rise(3);
            exp = exp_q.pop_front(); checks++;
            if ({irq, irq_a} !== exp[1:0]) begin
                errors++; $display("FAIL simul_after%0d: irq b/a=%b%b want %b", k, irq, irq_a, exp[1:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ppu_addr = 3'b100;
        exp_q.push_back(16'b00);
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_data = 8'h46; cpu_rw = 1'b0; cpu_m2 = 1'b1;
        cyc(2); cpu_m2 = 1'b0;
        cyc(1); rst_n = 1'b0;
        cyc(1);
        exp = exp_q.pop_front(); checks++;
        if ({irq, irq_a} !== exp[1:0]) begin
            errors++; $display("FAIL rstmid_irq: irq b/a=%b%b want %b", irq, irq_a, exp[1:0]);
        end
        cyc(1); rst_n = 1'b1;
        cyc(4); cpu_m2 = 1'b1;
        cyc(2); cpu_rw = 1'b1;
        exp_q.push_back(16'd0); exp_q.push_back(16'd1);
        exp_q.push_back(16'd62); exp_q.push_back(16'd63);
        for (int w = 0; w < 4; w++) begin
            cpu_addr = 16'(16'h8000 + w * 16'h2000); #1;
            exp = exp_q.pop_front(); checks++;
            if (prg_addr !== exp[PW-1:0]) begin
                errors++; $display("FAIL rstmid_prg_win%0d: got %0d want %0d", w, prg_addr, exp);
            end
        end
        exp_q.push_back(16'h0100);
        cpu_addr = 16'h6000; #1;
        exp = exp_q.pop_front(); checks++;
        if (chr_addr !== exp[7:0] || ram_ce !== exp[8]) begin
            errors++; $display("FAIL rstmid_chr_ram: chr=%h ram_ce=%b want %h/%b", chr_addr, ram_ce, exp[7:0], exp[8]);
        end
        exp_q.push_back(16'd1);
        ppu_addr = 3'b010; #1;
        exp = exp_q.pop_front(); checks++;
        if (ciram_a10 !== exp[0]) begin
            errors++; $display("FAIL rstmid_mirror: got %b want %b", ciram_a10, exp[0]);
        end
        cpu_addr = 16'h0000; ppu_addr = 3'b000;
    endtask

    task automatic test_latch0();
        do_reset();
        cpu_write(16'hE001, 8'h00);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'b10); exp_q.push_back(16'b00);
            a12_rise(3);
            exp = exp_q.pop_front(); checks++;
            if ({irq, irq_a} !== exp[1:0]) begin
                errors++; $display("FAIL latch0_clk%0d: irq b/a=%b%b want %b", k, irq, irq_a, exp[1:0]);
            end
            cpu_write(16'hE000, 8'h00);
            exp = exp_q.pop_front(); checks++;
            if ({irq, irq_a} !== exp[1:0]) begin
                errors++; $display("FAIL latch0_ack%0d: irq b/a=%b%b want %b", k, irq, irq_a, exp[1:0]);
            end
            cpu_write(16'hE001, 8'h00);
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_rw = 1'b1; cpu_m2 = 1'b1; mir_h = 1'b1;
        cpu_addr = 16'h0000; cpu_data = 8'h00; ppu_addr = 3'b000;
        test_reset();
        test_prg();
        test_chr_latency();
        test_chr();
        test_mirror_ram();
        test_irq();
        test_filter();
        test_simul();
        test_reset_mid();
        test_latch0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
